// File: rtl/in_to_fifo_pkg.sv
// Shared definitions for the byte-source to FIFO bridge blocks.
// Holds the state encodings of the in_to_fifo handshake FSM and the default
// FIFO-wait timeout, so the FIFO-side blocks agree on one set of values.
package in_to_fifo_pkg;

  // Handshake FSM state encodings (2-bit, kept as plain constants so older
  // blocks that compare against raw codes stay compatible).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACK   = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Default number of FIFO-wait cycles before a held byte is discarded.
  // Legal range is 2..255 because the wait counter is 8 bits wide.
  localparam int unsigned IN_TO_FIFO_TIMEOUT = 16;

  // Width of the data path and of the saturating drop counter.
  localparam int unsigned BYTE_W = 8;

  // Saturating increment used by the drop counter.
  function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] v);
    sat_inc = (v == {BYTE_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/in_to_fifo.sv
// Purpose : takes bytes from a 4-phase req/ack source and writes each one
//           into a FIFO with a single-cycle write strobe.
// Latency : in_valid rise -> fifo_we high is 3 cycles plus the time the
//           source takes to drop in_valid; at most one byte is in flight.
// Backpr. : while the FIFO is full/busy the byte is held for up to TIMEOUT
//           cycles, then dropped; drops set sticky overflow and bump a
//           saturating drop_count. enable=0 freezes everything.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   enable            1 = run, 0 = hold all state (fifo_we forced low)
//   in_valid, in_data source request and byte (4-phase handshake)
//   in_ack            acknowledge back to the source
//   fifo_busy/full    FIFO cannot accept a write when either is high
//   fifo_we, fifo_wdata  FIFO write strobe (one cycle) and byte
//   isIdle            high while the FSM sits in IDLE
//   overflow          sticky: at least one byte was dropped
//   clr_overflow      synchronous clear of overflow and drop_count
//   drop_count        saturating count of dropped bytes
module in_to_fifo
  import in_to_fifo_pkg::*;
#(
  parameter int unsigned TIMEOUT = IN_TO_FIFO_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ack,
  input  logic              fifo_busy,
  input  logic              fifo_full,
  output logic              fifo_we,
  output logic [BYTE_W-1:0] fifo_wdata,
  output logic              isIdle,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic [BYTE_W-1:0] drop_count
);

  // Terminal value of the wait counter: a byte is dropped on the cycle the
  // counter already sits at this value and the FIFO is still not ready.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state_q,  state_d;
  logic [7:0]        wait_q,   wait_d;
  logic              ack_d;
  logic              we_d;
  logic [BYTE_W-1:0] wdata_d;
  logic              idle_d;
  logic              drop;
  logic              fifo_ready;

  assign fifo_ready = !fifo_full && !fifo_busy;

  // ---------------------------------------------------------------------
  // Next-state / next-output logic. Every output is a register, so the
  // decode here computes the value each output takes at the next edge.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ack_d   = in_ack;
    we_d    = 1'b0;          // strobe is a pulse: low unless WRITE fires
    wdata_d = fifo_wdata;    // byte stays stable until the next latch
    idle_d  = isIdle;
    drop    = 1'b0;

    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          // Only IDLE ever samples in_data, so a request seen in any other
          // state cannot overwrite the byte currently being delivered.
          if (in_valid) begin
            wdata_d = in_data;
            ack_d   = 1'b1;
            wait_d  = 8'd0;
            idle_d  = 1'b0;
            state_d = ST_ACK;
          end
        end

        ST_ACK: begin
          // Hold the acknowledge until the source withdraws its request;
          // that completes the 4-phase handshake before the FIFO write.
          if (!in_valid) begin
            ack_d   = 1'b0;
            state_d = ST_WRITE;
          end
        end

        ST_WRITE: begin
          if (fifo_ready) begin
            we_d    = 1'b1;
            state_d = ST_DONE;
          end else if (wait_q >= WAIT_LAST) begin
            // Gave the FIFO its full wait budget: discard the byte.
            drop    = 1'b1;
            wait_d  = 8'd0;
            idle_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            wait_d  = wait_q + 8'd1;
          end
        end

        ST_DONE: begin
          we_d    = 1'b0;
          idle_d  = 1'b1;
          state_d = ST_IDLE;
        end

        default: begin
          ack_d   = 1'b0;
          wait_d  = 8'd0;
          idle_d  = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
    // With enable low everything above keeps its hold default and the
    // strobe stays low; a pending write in WRITE is simply retried once
    // enable returns because state_q is still WRITE.
  end

  // ---------------------------------------------------------------------
  // FSM and handshake/FIFO output registers.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_q     <= 8'd0;
      in_ack     <= 1'b0;
      fifo_we    <= 1'b0;
      fifo_wdata <= '0;
      isIdle     <= 1'b1;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      in_ack     <= ack_d;
      fifo_we    <= we_d;
      fifo_wdata <= wdata_d;
      isIdle     <= idle_d;
    end
  end

  // ---------------------------------------------------------------------
  // Drop bookkeeping. The clear is a software command and is honoured even
  // while the datapath is frozen; when it coincides with a drop the clear
  // wins and that drop is not counted.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clr_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= sat_inc(drop_count);
    end
  end

endmodule
